// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Two-cycle fetch/issue front end for a 16-bit program ROM.
//            Optional macro FETCH_ILLEGAL_TRAP_EN traps illegal opcodes.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [7:0] RST_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        rom_rd,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [3:0]  opcode,
  output logic [3:0]  rd_idx,
  output logic [3:0]  rs_idx,
  output logic [7:0]  imm,
  output logic [7:0]  issue_pc,
  input  logic        br_taken,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] c_OP_HALT = 4'hF;
  localparam logic [3:0] c_OP_JZ   = 4'h6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
`ifdef FETCH_ILLEGAL_TRAP_EN
    S_HALT  = 3'd3,
    S_TRAP  = 3'd4
`else
    S_HALT  = 3'd3
`endif
  } state_t;

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic [7:0]  w_pc_inc;
  logic [7:0]  w_next_pc;
  logic [3:0]  w_cap_op;
  logic        w_cap_legal;
  logic        w_handshake;

  // Decoded fields are straight slices of the instruction register, so they
  // stay stable for as long as the IR is held through an ISSUE stall.
  assign opcode = r_ir[15:12];
  assign rd_idx = r_ir[11:8];
  assign rs_idx = r_ir[7:4];
  assign imm    = r_ir[7:0];

  assign w_pc_inc    = r_pc + 8'd1;
  assign w_cap_op    = rom_data[15:12];
  assign w_handshake = instr_valid & instr_ready;
  assign w_next_pc   = ((r_ir[15:12] == c_OP_JZ) && br_taken) ? r_ir[7:0] : r_pc;

  always_comb begin
    w_cap_legal = 1'b0;
    case (w_cap_op)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: w_cap_legal = 1'b1;
      default:                                w_cap_legal = 1'b0;
    endcase
  end

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic r_illegal;
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RST_PC;
      r_ir        <= 16'h0000;
      rom_rd      <= 1'b0;
      rom_addr    <= RST_PC;
      instr_valid <= 1'b0;
      issue_pc    <= RST_PC;
      halted      <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      r_illegal   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state  <= S_FETCH;
            rom_rd   <= 1'b1;
            rom_addr <= r_pc;
          end
        end

        S_FETCH: begin
          rom_rd   <= 1'b0;
          r_ir     <= rom_data;
          issue_pc <= r_pc;
          r_pc     <= w_pc_inc;
          if (w_cap_op == c_OP_HALT) begin
            r_state <= S_HALT;
            halted  <= 1'b1;
          end else if (w_cap_legal) begin
            r_state     <= S_ISSUE;
            instr_valid <= 1'b1;
          end else begin
`ifdef FETCH_ILLEGAL_TRAP_EN
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
`else
            // Skip the bad word and fetch the next one straight away.
            r_state  <= S_FETCH;
            rom_rd   <= 1'b1;
            rom_addr <= w_pc_inc;
`endif
          end
        end

        S_ISSUE: begin
          if (w_handshake) begin
            instr_valid <= 1'b0;
            r_pc        <= w_next_pc;
            if (run) begin
              r_state  <= S_FETCH;
              rom_rd   <= 1'b1;
              rom_addr <= w_next_pc;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_HALT: r_state <= S_HALT;

`ifdef FETCH_ILLEGAL_TRAP_EN
        S_TRAP: r_state <= S_TRAP;
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit: ISA-level model plus pinned
//            literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        instr_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        rom_rd, instr_valid, halted, illegal;
  logic [7:0]  rom_addr, imm, issue_pc;
  logic [15:0] rom_data;
  logic [3:0]  opcode, rd_idx, rs_idx;

  logic        rom_rd_b, instr_valid_b, halted_b, illegal_b;
  logic [7:0]  rom_addr_b, imm_b, issue_pc_b;
  logic [15:0] rom_data_b;
  logic [3:0]  opcode_b, rd_idx_b, rs_idx_b;

  logic [15:0] rom [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rom_data   = rom[rom_addr];
  assign rom_data_b = rom[rom_addr_b];

  fetch_unit #(.RST_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst), .run(run),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd_idx(rd_idx), .rs_idx(rs_idx), .imm(imm),
    .issue_pc(issue_pc), .br_taken(br_taken),
    .halted(halted), .illegal(illegal)
  );

  // Second instance starts at the top of the address space to exercise wrap.
  fetch_unit #(.RST_PC(8'hFF)) u_dut_b (
    .clk(clk), .rst(rst), .run(run),
    .rom_rd(rom_rd_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .instr_valid(instr_valid_b), .instr_ready(1'b1),
    .opcode(opcode_b), .rd_idx(rd_idx_b), .rs_idx(rs_idx_b), .imm(imm_b),
    .issue_pc(issue_pc_b), .br_taken(1'b0),
    .halted(halted_b), .illegal(illegal_b)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ISA-level reference model ----------------
  typedef enum int {M_IDLE, M_FETCH, M_ISSUE, M_HALT, M_TRAP} mph_t;
  mph_t        m_phase = M_IDLE;
  logic [7:0]  m_pc = 8'h00;
  logic [7:0]  m_ipc = 8'h00;
  logic [15:0] m_ir = 16'h0000;
  logic        m_en = 1'b0;
  logic        prev_rst = 1'b0;

  always @(negedge clk) begin
    logic [15:0] w;
    logic [3:0]  op;
    if (rst) begin
      if (prev_rst) begin
        chk("rst_rom_rd", rom_rd, 16'd0);
        chk("rst_rom_addr", rom_addr, 16'h00);
        chk("rst_instr_valid", instr_valid, 16'd0);
        chk("rst_opcode", opcode, 16'd0);
        chk("rst_rd_idx", rd_idx, 16'd0);
        chk("rst_rs_idx", rs_idx, 16'd0);
        chk("rst_imm", imm, 16'd0);
        chk("rst_issue_pc", issue_pc, 16'h00);
        chk("rst_halted", halted, 16'd0);
        chk("rst_illegal", illegal, 16'd0);
      end
      m_phase = M_IDLE;
      m_pc    = 8'h00;
      m_en    = 1'b1;
    end else if (m_en) begin
      chk("halted", halted, 16'(m_phase == M_HALT));
      chk("illegal", illegal, 16'(m_phase == M_TRAP));
      chk("rom_rd", rom_rd, 16'(m_phase == M_FETCH));
      chk("instr_valid", instr_valid, 16'(m_phase == M_ISSUE));
      case (m_phase)
        M_IDLE: if (run) m_phase = M_FETCH;
        M_FETCH: begin
          chk("rom_addr", rom_addr, 16'(m_pc));
          w     = rom[m_pc];
          op    = w[15:12];
          m_ipc = m_pc;
          m_pc  = m_pc + 8'd1;
          if (op == 4'hF) m_phase = M_HALT;
          else if (op inside {[4'h2:4'h8]}) begin
            m_ir    = w;
            m_phase = M_ISSUE;
          end else begin
`ifdef FETCH_ILLEGAL_TRAP_EN
            m_phase = M_TRAP;
`else
            m_phase = M_FETCH;
`endif
          end
        end
        M_ISSUE: begin
          chk("opcode", opcode, 16'(m_ir[15:12]));
          chk("rd_idx", rd_idx, 16'(m_ir[11:8]));
          chk("rs_idx", rs_idx, 16'(m_ir[7:4]));
          chk("imm", imm, 16'(m_ir[7:0]));
          chk("issue_pc", issue_pc, 16'(m_ipc));
          if (instr_ready) begin
            if (m_ir[15:12] == 4'h6 && br_taken) m_pc = m_ir[7:0];
            m_phase = run ? M_FETCH : M_IDLE;
          end
        end
        default: ;
      endcase
    end
    prev_rst = rst;
  end

  // ---------------- Stimulus ----------------
  task automatic wait_valid();
    int waited = 0;
    while (!instr_valid && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("issue_wait", 16'(instr_valid), 16'd1);
  endtask

  task automatic issue_resp(input int stall, input logic bt, input logic run_after);
    wait_valid();
    repeat (stall) begin
      @(posedge clk); #1;
    end
    instr_ready = 1'b1;
    br_taken    = bt;
    run         = run_after;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    br_taken    = 1'b0;
  endtask

  task automatic wait_halt();
    int waited = 0;
    while (!halted && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("halt_wait", 16'(halted), 16'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h3000; rom[8'h01] = 16'h2123; rom[8'h02] = 16'h7345;
    rom[8'h03] = 16'h8A5C; rom[8'h04] = 16'h6108; rom[8'h05] = 16'h4010;
    rom[8'h06] = 16'h5ABC; rom[8'h07] = 16'h30FF; rom[8'h08] = 16'h6004;
    rom[8'h09] = 16'h6010; rom[8'h0A] = 16'h2000; rom[8'h0B] = 16'hF00B;
    rom[8'h10] = 16'h9000; rom[8'h11] = 16'h3777; rom[8'h12] = 16'hF000;
    rom[8'hFF] = 16'h3105;

    // Phase A: reset values, first fetch, branches, stall, halt
    do_reset();
    chk("b_rst_rom_addr", 16'(rom_addr_b), 16'h00FF);
    chk("b_rst_issue_pc", 16'(issue_pc_b), 16'h00FF);
    rst = 1'b0;
    run = 1'b1;
    @(posedge clk); #1;
    chk("first_rom_rd", 16'(rom_rd), 16'd1);
    chk("first_rom_addr", 16'(rom_addr), 16'h0000);
    chk("b_first_rom_addr", 16'(rom_addr_b), 16'h00FF);
    @(posedge clk); #1;
    chk("first_valid", 16'(instr_valid), 16'd1);
    chk("first_opcode", 16'(opcode), 16'h3);
    chk("first_rd_idx", 16'(rd_idx), 16'h0);
    chk("first_imm", 16'(imm), 16'h00);
    chk("first_issue_pc", 16'(issue_pc), 16'h00);
    @(posedge clk); #1;
    chk("b_wrap_rom_rd", 16'(rom_rd_b), 16'd1);
    chk("b_wrap_rom_addr", 16'(rom_addr_b), 16'h0000);

    issue_resp(0, 1'b0, 1'b1);          // 00
    for (int i = 0; i < 3; i++) issue_resp(0, 1'b0, 1'b1);  // 01..03
    issue_resp(0, 1'b1, 1'b1);          // 04 taken -> 08
    issue_resp(0, 1'b1, 1'b1);          // 08 taken -> 04
    issue_resp(0, 1'b0, 1'b1);          // 04 not taken -> 05
    issue_resp(3, 1'b0, 1'b1);          // 05 stalled three cycles
    chk("after_stall_rom_addr", 16'(rom_addr), 16'h0006);
    for (int i = 0; i < 5; i++) issue_resp(0, 1'b0, 1'b1);  // 06..0A
    wait_halt();
    repeat (5) @(posedge clk);
    #1;
    chk("halt_held", 16'(halted), 16'd1);
    chk("halt_no_rd", 16'(rom_rd), 16'd0);

    // Phase B: idle with ignored ready/br_taken, illegal opcode at 0x10
    do_reset();
    rst = 1'b0;
    run = 1'b1;
    issue_resp(0, 1'b0, 1'b0);          // 00 then idle
    instr_ready = 1'b1;
    br_taken    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_fetch", 16'(rom_rd), 16'd0);
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    run         = 1'b1;
    for (int i = 0; i < 8; i++) issue_resp(0, 1'b0, 1'b1);  // 01..08
    issue_resp(0, 1'b1, 1'b1);          // 09 taken -> 10 (illegal)
`ifdef FETCH_ILLEGAL_TRAP_EN
    repeat (6) @(posedge clk);
    #1;
    chk("trap_illegal", 16'(illegal), 16'd1);
    chk("trap_no_rd", 16'(rom_rd), 16'd0);
    chk("trap_no_valid", 16'(instr_valid), 16'd0);
`else
    wait_valid();
    chk("skip_issue_pc", 16'(issue_pc), 16'h0011);
    chk("skip_opcode", 16'(opcode), 16'h3);
    chk("skip_illegal_low", 16'(illegal), 16'd0);
    issue_resp(0, 1'b0, 1'b1);          // 11
    wait_halt();
`endif

    // Phase C: jump to 0xFF, wrap back to 0x00
    do_reset();
    rom[8'h00] = 16'h60FF;
    rst = 1'b0;
    run = 1'b1;
    issue_resp(0, 1'b1, 1'b1);          // 00 taken -> FF
    wait_valid();
    chk("ff_issue_pc", 16'(issue_pc), 16'h00FF);
    chk("ff_rd_idx", 16'(rd_idx), 16'h1);
    issue_resp(0, 1'b0, 1'b0);          // FF then idle
    run = 1'b1;
    @(posedge clk); #1;
    chk("wrap_rom_rd", 16'(rom_rd), 16'd1);
    chk("wrap_rom_addr", 16'(rom_addr), 16'h0000);
    issue_resp(0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
